seven_seg_scan_ctrl: RTL
========================

// Module: seven_seg_scan_ctrl
// PURPOSE
//  Time-multiplexing controller for the 4-digit seven-segment display.
//  - Rotates the active-low one-hot anode across the four digits, with a blanking gap between digits to suppress ghosting.
//  - Holds the displayed value set (val, lower_y, upper_y) in shadow registers.
//  - Accepts new values via a load/ack handshake and commits them only at a frame boundary, so no frame tears.
//  - Sits between the game/datapath logic and seven_seg_decoder; anode and digit outputs feed the decoder directly.
// PARAMETERS
//  PRESCALE      100000  clk cycles per digit slot (blank + drive); 1 kHz digit rate at 100 MHz
//  BLANK_CYCLES  1000    cycles per slot with all anodes off; legal range 1 <= BLANK_CYCLES < PRESCALE
// PORTS
//  clk         in   1  system clock; all state on rising edge
//  rst_n       in   1  asynchronous reset, active-low
//  en          in   1  1 = scan display; 0 = display dark
//  load        in   1  request to take val_in/lower_y_in/upper_y_in
//  val_in      in   4  new right-digit value
//  lower_y_in  in   4  new left-center value
//  upper_y_in  in   4  new left value
//  anode       out  4  active-low digit enable: 1110 R, 1101 RC, 1011 LC, 0111 L, 1111 off
//  val         out  4  committed right-digit value (to decoder)
//  lower_y     out  4  committed left-center value
//  upper_y     out  4  committed left value
//  load_ack    out  1  one-cycle pulse: a load was committed
//  frame_tick  out  1  one-cycle pulse at start of each frame (digit 0 blank)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state OFF, digit index 0, slot counter 0, anode=1111.
//    val/lower_y/upper_y=0; load_ack=0; frame_tick=0; pending flag and pending data cleared.
//  - FSM states:
//    - OFF: anode=1111.
//    - BLANK: anode=1111 for BLANK_CYCLES cycles.
//    - DRIVE: anode=one-hot(idx) for PRESCALE-BLANK_CYCLES cycles.
//  - Transitions:
//    - OFF->BLANK(idx0) when en=1.
//    - BLANK->DRIVE when the counter expires.
//    - DRIVE->BLANK(idx+1 mod 4) when the counter expires; idx3 wraps to idx0.
//    - Any state->OFF the cycle after en=0 is sampled: anode=1111 on that edge, idx and counter cleared.
//  - Frame: 4*PRESCALE cycles; digit order 1110,1101,1011,0111, then wrap.
//  - frame_tick=1 in the first cycle of BLANK for idx0, including the first slot after leaving OFF.
//  - Load handshake:
//    - load=1 captures *_in into pending regs and sets pending; a later load overwrites (latest wins).
//    - Commit edge: the edge that enters BLANK for idx0.
//      - Pending data is copied to val/lower_y/upper_y; pending is cleared.
//      - load_ack=1 for exactly the cycle after the commit edge.
//    - load=1 on the commit edge: the *_in data is committed directly (bypass), with one ack.
//    - In OFF: loads commit on the next edge, with ack the following cycle (no frame to protect).
//    - Multiple loads folded into one commit produce exactly one ack.
//  - en falling with pending=1: pending is retained, then committed immediately in OFF.
//  - Counter width: $clog2(PRESCALE); compares against PRESCALE-1 and BLANK_CYCLES-1.
//    No wrap aliasing is allowed.
//  - Outputs are registered; anode has no combinational path from en or load.
//  - Async reset mid-DRIVE: anode goes to 1111 immediately, without waiting for a clock.
// STRUCTURE
//  - Shared package seven_seg_pkg:
//    - ANODE_R=4'b1110, ANODE_RC=4'b1101, ANODE_LC=4'b1011, ANODE_L=4'b0111, ANODE_OFF=4'b1111.
//    - Scan state encoding: S_OFF, S_BLANK, S_DRIVE.
//    - NUM_DIGITS=4.
//  - One sub-module: scan_timer.
//    - Parameterised down-counter with a load port.
//    - Outputs a done pulse, used for both the BLANK and DRIVE intervals.
//  - Top-level FSM, digit index, pending/shadow regs and handshake live in seven_seg_scan_ctrl.
// TESTING  (PRESCALE=8, BLANK_CYCLES=2; frame=32 cycles)
//  1. Reset with rst_n=0, en=1 -> anode=1111, val=lower_y=upper_y=0, load_ack=0, frame_tick=0.
//  2. Release rst_n with en=1 -> the sequence repeats every 32 cycles:
//     2x1111 + 6x1110, 2x1111 + 6x1101, 2x1111 + 6x1011, 2x1111 + 6x0111.
//     frame_tick fires once per 32 cycles.
//  3. load=1 for 1 cycle during the 1011 slot with val_in=5, lower_y_in=3, upper_y_in=9 ->
//     outputs hold old values until the idx0 BLANK edge, then show 5/3/9; load_ack fires exactly once.
//  4. Loads 1/2/3 then 7/8/9 in the same frame -> commits 7/8/9, a single load_ack.
//     A load coincident with the commit edge -> its own data is committed (bypass).
//  5. en=0 mid 1101 slot -> anode=1111 the next cycle.
//     A load of A/B/C while OFF -> committed in 1 cycle.
//     en=1 -> restarts at idx0 BLANK with frame_tick.
//  6. Drop rst_n asynchronously mid-DRIVE between clock edges ->
//     anode=1111 and outputs 0 before the next clk edge; normal scan resumes after release.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment display path: anode codes, scan
// states and the committed display value bundle.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [3:0] ANODE_R   = 4'b1110;
  localparam logic [3:0] ANODE_RC  = 4'b1101;
  localparam logic [3:0] ANODE_LC  = 4'b1011;
  localparam logic [3:0] ANODE_L   = 4'b0111;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  typedef enum logic [1:0] {
    S_OFF,
    S_BLANK,
    S_DRIVE
  } scan_state_t;

  typedef struct packed {
    logic [3:0] val;
    logic [3:0] lower_y;
    logic [3:0] upper_y;
  } disp_vals_t;

  function automatic logic [3:0] digit_anode(input logic [1:0] idx);
    case (idx)
      2'd0:    digit_anode = ANODE_R;
      2'd1:    digit_anode = ANODE_RC;
      2'd2:    digit_anode = ANODE_LC;
      default: digit_anode = ANODE_L;
    endcase
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter; done is high while the count sits at zero, so an
// interval loaded with N-1 lasts exactly N cycles.
module scan_timer #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit seven-segment scan controller: blanked anode rotation plus
// frame-aligned commit of display values through a load/ack handshake.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] val_in,
  input  logic [3:0] lower_y_in,
  input  logic [3:0] upper_y_in,
  output logic [3:0] anode,
  output logic [3:0] val,
  output logic [3:0] lower_y,
  output logic [3:0] upper_y,
  output logic       load_ack,
  output logic       frame_tick
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIVE_LOAD = CNT_W'(PRESCALE - BLANK_CYCLES - 1);

  scan_state_t      state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       anode_q, anode_d;
  disp_vals_t       shadow_q, shadow_d;
  disp_vals_t       pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             ack_q, ack_d;
  logic             tick_q, tick_d;
  logic             tmr_load, tmr_done;
  logic [CNT_W-1:0] tmr_val;
  logic             frame_start, commit;
  disp_vals_t       in_vals;

  scan_timer #(.WIDTH(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // NOTE: every combinational output is defaulted first so no path through
  // the case/if tree leaves one unassigned and infers a latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (!en) begin
      state_d  = S_OFF;
      idx_d    = 2'd0;
      tmr_load = 1'b1;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d  = S_BLANK;
          idx_d    = 2'd0;
          tmr_load = 1'b1;
          tmr_val  = BLANK_LOAD;
        end
        S_BLANK: if (tmr_done) begin
          state_d  = S_DRIVE;
          tmr_load = 1'b1;
          tmr_val  = DRIVE_LOAD;
        end
        S_DRIVE: if (tmr_done) begin
          state_d  = S_BLANK;
          idx_d    = idx_q + 2'd1;
          tmr_load = 1'b1;
          tmr_val  = BLANK_LOAD;
        end
        default: state_d = S_OFF;
      endcase
    end

    // Anode is computed from the next state so the register itself is the output.
    anode_d     = (state_d == S_DRIVE) ? digit_anode(idx_d) : ANODE_OFF;
    frame_start = (state_d == S_BLANK) && (state_q != S_BLANK) && (idx_d == 2'd0);
    commit      = frame_start || (state_q == S_OFF);
    tick_d      = frame_start;

    in_vals.val     = val_in;
    in_vals.lower_y = lower_y_in;
    in_vals.upper_y = upper_y_in;

    shadow_d   = shadow_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ack_d      = 1'b0;
    if (commit) begin
      // A load on the commit edge is newer than anything pending, so it wins.
      if (load) begin
        shadow_d = in_vals;
        ack_d    = 1'b1;
      end else if (pend_vld_q) begin
        shadow_d = pend_q;
        ack_d    = 1'b1;
      end
      pend_vld_d = 1'b0;
    end else if (load) begin
      pend_d     = in_vals;
      pend_vld_d = 1'b1;
    end
  end

  // NOTE: pending data is reset along with its valid flag; it is only a few
  // bits, and a clean reset keeps it out of X-propagation debates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_OFF;
      idx_q      <= 2'd0;
      anode_q    <= ANODE_OFF;
      shadow_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ack_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      anode_q    <= anode_d;
      shadow_q   <= shadow_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ack_q      <= ack_d;
      tick_q     <= tick_d;
    end
  end

  assign anode      = anode_q;
  assign val        = shadow_q.val;
  assign lower_y    = shadow_q.lower_y;
  assign upper_y    = shadow_q.upper_y;
  assign load_ack   = ack_q;
  assign frame_tick = tick_q;

endmodule
